lut_stream_loader: RTL and testbench
====================================

// Module: lut_stream_loader
// PURPOSE
//  Streams words into a synchronous LUT RAM at sequential addresses; the write-side counterpart of the registered LUT reader.
//  Software or link logic arms a load (base address, word count) and pushes data over valid/ready.
//  The block drives the RAM write port with registered wea/addr/din and reports completion, wrap and checksum status.
// PARAMETERS
//  MXADRB     9            RAM address width
//  MXDATB     11           RAM data width
//  ROMLENGTH  1<<MXADRB    RAM depth in words; the address wraps modulo ROMLENGTH
// PORTS
//  clka       in   1          clock
//  rstn       in   1          asynchronous active-low reset
//  start      in   1          1-cycle arm pulse; sampled only in IDLE
//  abort      in   1          cancels the load in progress; sampled only in LOAD
//  base_addr  in   MXADRB     first write address, captured on start
//  nwords     in   MXADRB+1   word count, captured on start; 0 to ROMLENGTH
//  s_data     in   MXDATB     stream data
//  s_valid    in   1          stream valid
//  s_ready    out  1          stream ready
//  wea        out  1          RAM write enable
//  addra      out  MXADRB     RAM write address
//  dina       out  MXDATB     RAM write data
//  busy       out  1          high in LOAD
//  done       out  1          1-cycle completion pulse
//  err_wrap   out  1          sticky: address wrapped past ROMLENGTH-1
//  csum_ok    out  1          only with LUT_LOADER_CSUM_EN; see CONFIGURATION
//  exp_csum   in   MXDATB     only with LUT_LOADER_CSUM_EN; expected XOR checksum
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; address counter and remaining-word counter 0.
//  Reset asserted mid-load abandons the load immediately. No done pulse is generated.
//  States: IDLE, LOAD, DONE.
//   IDLE: s_ready=0.
//    - start with nwords!=0: capture base_addr/nwords, clear err_wrap, go to LOAD.
//    - start with nwords==0: done=1 on the next cycle, stay in IDLE, no writes.
//   LOAD: s_ready=1, busy=1.
//    - A handshake occurs when s_valid&&s_ready.
//    - Each handshake in cycle N gives wea=1, addra=current address, dina=s_data in cycle N+1.
//    - Each handshake increments the address mod ROMLENGTH and decrements the remaining count.
//    - Full throughput: one word per cycle. s_valid low inserts bubbles; wea=0 in those cycles.
//    - A handshake on the last word (remaining==1) moves to DONE; s_ready drops in cycle N+1.
//    - abort=1 returns to IDLE. A handshake in the same cycle is still written; no further words are accepted; no done pulse.
//   DONE: one cycle, done=1 (same cycle as the final wea), then IDLE.
//    - start is ignored in DONE and in LOAD.
//  Wrap: the address increments from ROMLENGTH-1 to 0. err_wrap sets in the cycle of that write and holds until the next accepted start.
//  nwords > ROMLENGTH is clamped to ROMLENGTH.
//  wea is never asserted outside the cycle following a handshake.
// CONFIGURATION
//  LUT_LOADER_CSUM_EN defined:
//   - A running XOR of accepted words is cleared on start.
//   - In DONE, csum_ok <= (xor == exp_csum). It holds until the next start, which clears it to 0.
//   - An aborted load leaves csum_ok=0.
//  LUT_LOADER_CSUM_EN undefined:
//   - exp_csum and csum_ok are absent; no checksum logic is built.
// TESTING
//  1. base=0x010, nwords=4, data A,B,C,D, s_valid held high -> wea on 4 consecutive cycles at addra 0x010..0x013; done with the 4th write; err_wrap=0.
//  2. Same as 1 but s_valid toggles 1,0,1,0 -> exactly 4 writes at increasing addresses; wea=0 in bubble cycles; done 1 cycle after the last handshake.
//  3. base=0x1FE, nwords=4 (MXADRB=9) -> writes at 0x1FE,0x1FF,0x000,0x001; err_wrap rises with the 0x000 write and stays set.
//  4. nwords=8, abort asserted with the 3rd handshake -> 3 writes, s_ready=0 next cycle, no done, busy=0; a new start is then accepted.
//  5. nwords=0 start -> done pulse 1 cycle later, no wea; rstn low during LOAD -> all outputs 0 immediately; start during LOAD is ignored.
//  6. CSUM_EN: data 0x001,0x002,0x004 with exp_csum=0x007 -> csum_ok=1 at done; rerun with exp_csum=0x006 -> csum_ok=0.

Source files
------------

// File: rtl/lut_stream_loader.sv
// lut_stream_loader: streams words into a synchronous LUT RAM at sequential
// addresses. A load is armed with a base address and word count, data arrives
// over valid/ready, and the RAM write port (wea/addra/dina) is driven from
// registers one cycle after each handshake. Reports done, a sticky address-wrap
// flag and, optionally, an XOR checksum result.
// Optional feature macro: LUT_LOADER_CSUM_EN (adds exp_csum input, csum_ok output).
module lut_stream_loader #(
    parameter int MXADRB    = 9,
    parameter int MXDATB    = 11,
    parameter int ROMLENGTH = 1 << MXADRB
) (
    input  logic              clka,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [MXADRB-1:0] base_addr,
    input  logic [MXADRB:0]   nwords,
    input  logic [MXDATB-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wea,
    output logic [MXADRB-1:0] addra,
    output logic [MXDATB-1:0] dina,
    output logic              busy,
    output logic              done,
    output logic              err_wrap
`ifdef LUT_LOADER_CSUM_EN
    ,
    output logic              csum_ok,
    input  logic [MXDATB-1:0] exp_csum
`endif
);

    localparam logic [MXADRB-1:0] ADDR_MAX = MXADRB'(ROMLENGTH - 1);
    localparam logic [MXADRB:0]   DEPTH    = (MXADRB + 1)'(ROMLENGTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MXADRB-1:0]   addr_q, addr_d;       // next RAM address to write
    logic [MXADRB:0]     rem_q, rem_d;         // words still to accept
    logic                wrap_q, wrap_d;       // counter has rolled over to 0
    logic                wea_q, wea_d;
    logic [MXADRB-1:0]   addra_q, addra_d;
    logic [MXDATB-1:0]   dina_q, dina_d;
    logic                done_q, done_d;
    logic                err_wrap_q, err_wrap_d;
`ifdef LUT_LOADER_CSUM_EN
    logic [MXDATB-1:0]   csum_q, csum_d;
    logic                csum_ok_q, csum_ok_d;
    logic [MXDATB-1:0]   csum_next;
`endif

    logic handshake;
    logic last_word;
    logic [MXADRB:0] nwords_clamped;

    assign handshake      = (state_q == ST_LOAD) && s_valid;
    assign last_word      = (rem_q == {{MXADRB{1'b0}}, 1'b1});
    assign nwords_clamped = (nwords > DEPTH) ? DEPTH : nwords;

    assign s_ready  = (state_q == ST_LOAD);
    assign busy     = (state_q == ST_LOAD);
    assign wea      = wea_q;
    assign addra    = addra_q;
    assign dina     = dina_q;
    assign done     = done_q;
    assign err_wrap = err_wrap_q;
`ifdef LUT_LOADER_CSUM_EN
    assign csum_ok   = csum_ok_q;
    assign csum_next = csum_q ^ s_data;
`endif

    // Next-state logic: abort has priority over completing the final word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && (nwords != '0)) state_d = ST_LOAD;
            ST_LOAD: begin
                if (abort)                       state_d = ST_IDLE;
                else if (handshake && last_word) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: arming, per-handshake write staging, wrap and checksum.
    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        wrap_d     = wrap_q;
        wea_d      = 1'b0;
        addra_d    = addra_q;
        dina_d     = dina_q;
        done_d     = 1'b0;
        err_wrap_d = err_wrap_q;
`ifdef LUT_LOADER_CSUM_EN
        csum_d     = csum_q;
        csum_ok_d  = csum_ok_q;
`endif
        if ((state_q == ST_IDLE) && start) begin
`ifdef LUT_LOADER_CSUM_EN
            csum_d    = '0;
            csum_ok_d = 1'b0;
`endif
            if (nwords != '0) begin
                addr_d     = base_addr;
                rem_d      = nwords_clamped;
                wrap_d     = 1'b0;
                err_wrap_d = 1'b0;
            end else begin
                // Empty load completes immediately without touching the RAM.
                done_d = 1'b1;
            end
        end
        if (handshake) begin
            wea_d   = 1'b1;
            addra_d = addr_q;
            dina_d  = s_data;
            rem_d   = rem_q - 1'b1;
            if (addr_q == ADDR_MAX) begin
                addr_d = '0;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
            // Any write after the rollover lands at the wrapped address.
            if (wrap_q) err_wrap_d = 1'b1;
`ifdef LUT_LOADER_CSUM_EN
            csum_d = csum_next;
`endif
            if (last_word && !abort) begin
                done_d = 1'b1;
`ifdef LUT_LOADER_CSUM_EN
                // Result becomes visible together with done and holds until next start.
                csum_ok_d = (csum_next == exp_csum);
`endif
            end
        end
    end

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            wrap_q     <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            done_q     <= 1'b0;
            err_wrap_q <= 1'b0;
`ifdef LUT_LOADER_CSUM_EN
            csum_q     <= '0;
            csum_ok_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wrap_q     <= wrap_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            done_q     <= done_d;
            err_wrap_q <= err_wrap_d;
`ifdef LUT_LOADER_CSUM_EN
            csum_q     <= csum_d;
            csum_ok_q  <= csum_ok_d;
`endif
        end
    end

endmodule

// File: tb/tb_lut_stream_loader.sv
// Directed testbench for lut_stream_loader (default parameters MXADRB=9, MXDATB=11).
// Checksum scenario is compiled only with LUT_LOADER_CSUM_EN.
module tb_lut_stream_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [8:0]  base_addr = '0;
    logic [9:0]  nwords = '0;
    logic [10:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        wea;
    logic [8:0]  addra;
    logic [10:0] dina;
    logic        busy;
    logic        done;
    logic        err_wrap;
`ifdef LUT_LOADER_CSUM_EN
    logic        csum_ok;
    logic [10:0] exp_csum = '0;
`endif

    int checks = 0;
    int errors = 0;

    lut_stream_loader dut (
        .clka      (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .nwords    (nwords),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .busy      (busy),
        .done      (done),
        .err_wrap  (err_wrap)
`ifdef LUT_LOADER_CSUM_EN
        ,
        .csum_ok   (csum_ok),
        .exp_csum  (exp_csum)
`endif
    );

    always #5 clk = ~clk;

    // One line per RAM write transaction.
    always @(negedge clk) begin
        if (wea) $display("write addr=%03h data=%03h done=%0d err_wrap=%0d", addra, dina, done, err_wrap);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({s_ready, wea, addra, dina, busy, done, err_wrap} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {s_ready, wea, addra, dina, busy, done, err_wrap});
        end
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_full_rate();
        logic [10:0] d [4];
        logic [21:0] act, exp;
        d = '{11'h0A1, 11'h0B2, 11'h0C3, 11'h0D4};
        start = 1'b1; base_addr = 9'h010; nwords = 10'd4;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, s_ready, wea, done} !== 4'b1100) begin
            errors++;
            $display("FAIL full_rate_armed: got %b expected 1100", {busy, s_ready, wea, done});
        end
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = d[k];
            tick();
            act = {wea, addra, dina, done};
            exp = {1'b1, 9'h010 + 9'(k), d[k], (k == 3)};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL full_rate_word%0d: got %h expected %h", k, act, exp);
            end
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if ({wea, done, busy, err_wrap} !== 4'b0000) begin
            errors++;
            $display("FAIL full_rate_end: got %b expected 0000", {wea, done, busy, err_wrap});
        end
    endtask

    task automatic test_bubbles();
        logic [10:0] d [4];
        logic [21:0] act, exp;
        int hc = 0;
        d = '{11'h111, 11'h222, 11'h333, 11'h444};
        start = 1'b1; base_addr = 9'h010; nwords = 10'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = s_valid ? d[hc] : 11'h7FF;
            tick();
            if (i % 2 == 0) begin
                act = {wea, addra, dina, done};
                exp = {1'b1, 9'h010 + 9'(hc), d[hc], (hc == 3)};
                hc++;
            end else begin
                act = {wea, 9'h000, 11'h000, done};
                exp = '0;
            end
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL bubbles_cycle%0d: got %h expected %h", i, act, exp);
            end
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if ({wea, done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL bubbles_end: got %b expected 000", {wea, done, busy});
        end
    endtask

    task automatic test_wrap();
        logic [8:0]  ea [4];
        logic [11:0] act, exp;
        ea = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        start = 1'b1; base_addr = 9'h1FE; nwords = 10'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = 11'h050 + 11'(k);
            tick();
            act = {wea, addra, err_wrap, done};
            exp = {1'b1, ea[k], (k >= 2), (k == 3)};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h expected %h", k, act, exp);
            end
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if ({err_wrap, done} !== 2'b10) begin
            errors++;
            $display("FAIL wrap_sticky: got %b expected 10", {err_wrap, done});
        end
    endtask

    task automatic test_abort();
        logic [20:0] act, exp;
        start = 1'b1; base_addr = 9'h020; nwords = 10'd8;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, err_wrap} !== 2'b10) begin
            errors++;
            $display("FAIL abort_start_clears_wrap: got %b expected 10", {busy, err_wrap});
        end
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 11'h100 + 11'(k); abort = (k == 2);
            tick();
            act = {wea, addra, dina};
            exp = {1'b1, 9'h020 + 9'(k), 11'h100 + 11'(k)};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL abort_word%0d: got %h expected %h", k, act, exp);
            end
        end
        checks++;
        if ({s_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_state: got %b expected 000", {s_ready, busy, done});
        end
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({wea, done} !== 2'b00) begin
                errors++;
                $display("FAIL abort_idle%0d: got %b expected 00", k, {wea, done});
            end
        end
        s_valid = 1'b0;
        start = 1'b1; base_addr = 9'h005; nwords = 10'd1;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 11'h3AB;
        tick();
        s_valid = 1'b0;
        act = {wea, addra, dina};
        checks++;
        if ({act, done} !== {1'b1, 9'h005, 11'h3AB, 1'b1}) begin
            errors++;
            $display("FAIL abort_restart: got %h expected %h", {act, done}, {1'b1, 9'h005, 11'h3AB, 1'b1});
        end
        tick();
    endtask

    task automatic test_zero_and_reset();
        start = 1'b1; base_addr = 9'h050; nwords = 10'd0;
        tick();
        start = 1'b0;
        checks++;
        if ({done, wea, busy} !== 3'b100) begin
            errors++;
            $display("FAIL zero_done: got %b expected 100", {done, wea, busy});
        end
        tick();
        checks++;
        if ({done, wea} !== 2'b00) begin
            errors++;
            $display("FAIL zero_after: got %b expected 00", {done, wea});
        end
        start = 1'b1; base_addr = 9'h030; nwords = 10'd3;
        tick();
        // Keep start high with a different request while loading.
        base_addr = 9'h100; nwords = 10'd1;
        s_valid = 1'b1; s_data = 11'h011;
        tick();
        checks++;
        if ({wea, addra, done} !== {1'b1, 9'h030, 1'b0}) begin
            errors++;
            $display("FAIL ignore_start_w0: got %h expected %h", {wea, addra, done}, {1'b1, 9'h030, 1'b0});
        end
        s_data = 11'h012;
        tick();
        checks++;
        if ({wea, addra, done, busy} !== {1'b1, 9'h031, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ignore_start_w1: got %h expected %h", {wea, addra, done, busy}, {1'b1, 9'h031, 1'b0, 1'b1});
        end
        start = 1'b0; s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        checks++;
        if ({s_ready, wea, addra, dina, busy, done, err_wrap} !== 25'd0) begin
            errors++;
            $display("FAIL midload_reset: got %h expected 0", {s_ready, wea, addra, dina, busy, done, err_wrap});
        end
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if ({busy, done, wea} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 000", {busy, done, wea});
        end
    endtask

    task automatic test_clamp();
        int  cnt = 0;
        bit  seen_done = 1'b0;
        start = 1'b1; base_addr = 9'h000; nwords = 10'h3FF;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            s_data = 11'(i);
            tick();
            if (wea) cnt++;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        checks++;
        if (!seen_done || cnt != 512) begin
            errors++;
            $display("FAIL clamp_count: got writes=%0d done=%0d expected writes=512 done=1", cnt, seen_done);
        end
        checks++;
        if (err_wrap !== 1'b0) begin
            errors++;
            $display("FAIL clamp_no_wrap: got %b expected 0", err_wrap);
        end
        tick();
    endtask

`ifdef LUT_LOADER_CSUM_EN
    task automatic test_csum();
        logic [10:0] d [3];
        d = '{11'h001, 11'h002, 11'h004};
        for (int run = 0; run < 2; run++) begin
            exp_csum = (run == 0) ? 11'h007 : 11'h006;
            start = 1'b1; base_addr = 9'h040; nwords = 10'd3;
            tick();
            start = 1'b0;
            if (run == 1) begin
                checks++;
                if (csum_ok !== 1'b0) begin
                    errors++;
                    $display("FAIL csum_cleared_on_start: got %b expected 0", csum_ok);
                end
            end
            for (int k = 0; k < 3; k++) begin
                s_valid = 1'b1; s_data = d[k];
                tick();
            end
            s_valid = 1'b0;
            checks++;
            if ({done, csum_ok} !== {1'b1, (run == 0)}) begin
                errors++;
                $display("FAIL csum_run%0d_at_done: got %b expected %b", run, {done, csum_ok}, {1'b1, (run == 0)});
            end
            tick();
            checks++;
            if (csum_ok !== (run == 0)) begin
                errors++;
                $display("FAIL csum_run%0d_hold: got %b expected %b", run, csum_ok, (run == 0));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_rate();
        test_bubbles();
        test_wrap();
        test_abort();
        test_zero_and_reset();
        test_clamp();
`ifdef LUT_LOADER_CSUM_EN
        test_csum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
